// File: rtl/melody_player_if.sv
// Song ROM port bundle: the player drives the address, the synchronous ROM returns
// the {dur,note} word one clock later.
interface melody_player_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 10
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/melody_player.sv
// Song ROM walker with tempo prescaler and square-wave tone generator.
// Optional looping (extra `loop` input) is enabled by defining MELODY_PLAYER_LOOP_EN.
module melody_player #(
    parameter int unsigned CLK_HZ  = 1_000_000,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DUR_W   = 4,
    parameter int unsigned NOTE_W  = 6,
    parameter int unsigned TEMPO_W = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pause,
`ifdef MELODY_PLAYER_LOOP_EN
    input  logic               loop,
`endif
    input  logic [TEMPO_W-1:0] tempo,
    melody_player_if.master    rom,
    output logic               busy,
    output logic               done,
    output logic               spk
);

    // Half-period in clk cycles for octave 0 (C3..B3); higher octaves shift right.
    localparam longint unsigned HALF = 64'(CLK_HZ) * 64'd50;
    localparam int unsigned HP_TAB [12] = '{
        32'(HALF / 64'd13081), 32'(HALF / 64'd13859), 32'(HALF / 64'd14683),
        32'(HALF / 64'd15556), 32'(HALF / 64'd16481), 32'(HALF / 64'd17461),
        32'(HALF / 64'd18500), 32'(HALF / 64'd19600), 32'(HALF / 64'd20765),
        32'(HALF / 64'd22000), 32'(HALF / 64'd23308), 32'(HALF / 64'd24694)
    };
    localparam int unsigned HP_MAX = 32'(HALF / 64'd13081);
    localparam int unsigned TONE_W = $clog2(HP_MAX + 1);

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StPlay, StEnd} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [TEMPO_W-1:0]  tick_q, tick_d;
    logic [TONE_W-1:0]   tone_q, tone_d;
    logic                phase_q, phase_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                spk_q, spk_d;

    logic                loop_en;
    logic [3:0]          semi;
    logic [1:0]          oct;
    logic                rest;
    logic [31:0]         hp_raw, hp;
    logic [TEMPO_W-1:0]  tempo_m1;
    logic                tone_wrap, tick_wrap, last_addr;
    logic [DUR_W-1:0]    rom_dur;
    logic [NOTE_W-1:0]   rom_note;

`ifdef MELODY_PLAYER_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    assign semi      = note_q[3:0];
    assign oct       = note_q[5:4];
    assign rest      = (semi >= 4'd12);
    assign hp_raw    = HP_TAB[rest ? 4'd0 : semi] >> oct;
    assign hp        = (hp_raw == 32'd0) ? 32'd1 : hp_raw;
    assign tempo_m1  = (tempo == '0) ? '0 : tempo - TEMPO_W'(1);
    assign tone_wrap = (32'(tone_q) == hp - 32'd1);
    assign tick_wrap = (tick_q == tempo_m1);
    assign last_addr = &rom_addr_q;
    assign rom_dur   = rom.rom_data[DUR_W+NOTE_W-1:NOTE_W];
    assign rom_note  = rom.rom_data[NOTE_W-1:0];

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        dur_d      = dur_q;
        note_d     = note_q;
        tick_d     = tick_q;
        tone_d     = tone_q;
        phase_d    = phase_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        spk_d      = spk_q;

        // start wins over pause and over end-of-song; an aborted song never pulses done.
        if (start) begin
            state_d    = StFetch;
            rom_addr_d = '0;
            busy_d     = 1'b1;
            spk_d      = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StFetch: state_d = StLoad;
                StLoad: begin
                    dur_d   = rom_dur;
                    note_d  = rom_note;
                    tick_d  = '0;
                    tone_d  = '0;
                    phase_d = 1'b0;
                    spk_d   = 1'b0;
                    if (rom_dur == '0) begin
                        state_d = StEnd;
                        done_d  = 1'b1;
                        busy_d  = loop_en;
                    end else begin
                        state_d = StPlay;
                    end
                end
                StPlay: begin
                    if (pause) begin
                        spk_d = 1'b0;
                    end else begin
                        if (tone_wrap) begin
                            tone_d  = '0;
                            phase_d = ~phase_q;
                        end else begin
                            tone_d = tone_q + TONE_W'(1);
                        end
                        spk_d = phase_d & ~rest;
                        if (tick_wrap) begin
                            tick_d = '0;
                            dur_d  = dur_q - DUR_W'(1);
                            if (dur_q == DUR_W'(1)) begin
                                spk_d = 1'b0;
                                if (last_addr) begin
                                    state_d = StEnd;
                                    done_d  = 1'b1;
                                    busy_d  = loop_en;
                                end else begin
                                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                                    state_d    = StFetch;
                                end
                            end
                        end else begin
                            tick_d = tick_q + TEMPO_W'(1);
                        end
                    end
                end
                StEnd: begin
                    // busy still high here means the song was told to loop.
                    if (busy_q) begin
                        state_d    = StFetch;
                        rom_addr_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rom_addr_q <= '0;
            dur_q      <= '0;
            note_q     <= '0;
            tick_q     <= '0;
            tone_q     <= '0;
            phase_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            spk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            dur_q      <= dur_d;
            note_q     <= note_d;
            tick_q     <= tick_d;
            tone_q     <= tone_d;
            phase_q    <= phase_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            spk_q      <= spk_d;
        end
    end

    assign rom.rom_addr = rom_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign spk          = spk_q;

endmodule

// File: tb/tb_melody_player.sv
// Randomised bench for melody_player: a note-level timeline model predicts busy/done/spk/rom_addr
// for every clock after start; a second 2-bit-address instance covers the last-address stop.
module tb_melody_player;

    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 4;
    localparam int unsigned NW   = 6;
    localparam int unsigned TW   = 20;
    localparam int          MAXC = 16000;
    localparam int F100 [12] = '{13081, 13859, 14683, 15556, 16481, 17461,
                                 18500, 19600, 20765, 22000, 23308, 24694};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic [TW-1:0] tempo = '0;
    logic          busy, done, spk, busy2, done2, spk2;
    logic [DW+NW-1:0] mem [256];

    int exp_v [MAXC];
    bit pause_s [MAXC];
    int last;
    int n_tests = 0;
    int n_fail = 0;

    melody_player_if #(.ADDR_W(AW), .DATA_W(DW + NW)) rif ();
    melody_player_if #(.ADDR_W(2),  .DATA_W(DW + NW)) rif2 ();

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        rif.rom_data  <= mem[rif.rom_addr];
        rif2.rom_data <= mem[{6'd0, rif2.rom_addr}];
    end

    melody_player #(.CLK_HZ(1_000_000), .ADDR_W(AW), .DUR_W(DW), .NOTE_W(NW), .TEMPO_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .pause (pause),
`ifdef MELODY_PLAYER_LOOP_EN
        .loop  (1'b0),
`endif
        .tempo (tempo),
        .rom   (rif),
        .busy  (busy),
        .done  (done),
        .spk   (spk)
    );

    melody_player #(.CLK_HZ(1_000_000), .ADDR_W(2), .DUR_W(DW), .NOTE_W(NW), .TEMPO_W(TW)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .pause (pause),
`ifdef MELODY_PLAYER_LOOP_EN
        .loop  (1'b0),
`endif
        .tempo (tempo),
        .rom   (rif2),
        .busy  (busy2),
        .done  (done2),
        .spk   (spk2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void put(input int c, input int b, input int d, input int s, input int a);
        if (c >= 0 && c < MAXC) exp_v[c] = (b << 10) | (d << 9) | (s << 8) | a;
    endfunction

    // Expected {busy,done,spk,addr} after each edge, for a start seen at edge `base`.
    task automatic gen(input int base, input int amax, input int t_eff);
        int e, addr, dur, semi, oct, hp, elapsed, total;
        bit fin, stop;
        e = base;
        addr = 0;
        fin = 0;
        put(e, 1, 0, 0, 0);
        while (!fin && e < MAXC) begin
            put(e + 1, 1, 0, 0, addr);
            put(e + 2, 1, 0, 0, addr);
            dur  = int'(mem[addr]) >> NW;
            semi = int'(mem[addr]) & 15;
            oct  = (int'(mem[addr]) >> 4) & 3;
            if (dur == 0) begin
                put(e + 2, 0, 1, 0, addr);
                e = e + 2;
                fin = 1;
            end else begin
                hp = (semi < 12) ? ((50_000_000 / F100[semi]) >> oct) : 1;
                total = dur * t_eff;
                elapsed = 0;
                e = e + 3;
                stop = 0;
                while (!stop && e < MAXC) begin
                    if (pause_s[e]) begin
                        put(e, 1, 0, 0, addr);
                        e++;
                    end else begin
                        elapsed++;
                        if (elapsed == total) begin
                            if (addr == amax) begin
                                put(e, 0, 1, 0, addr);
                                fin = 1;
                            end else begin
                                addr++;
                                put(e, 1, 0, 0, addr);
                            end
                            stop = 1;
                        end else begin
                            put(e, 1, 0, (semi < 12) ? ((elapsed / hp) % 2) : 0, addr);
                            e++;
                        end
                    end
                end
            end
        end
        for (int i = e + 1; i <= e + 4; i++) put(i, 0, 0, 0, addr);
        last = (e + 4 < MAXC) ? e + 4 : MAXC - 1;
    endtask

    task automatic clear_pause();
        for (int i = 0; i < MAXC; i++) pause_s[i] = 1'b0;
    endtask

    task automatic run(input bit sel, input int abort_in);
        int t_eff, abort_at;
        logic [31:0] obs;
        t_eff = (tempo == '0) ? 1 : int'(tempo);
        abort_at = abort_in;
        gen(0, sel ? 3 : 255, t_eff);
        if (abort_at > last) abort_at = last;
        if (abort_at > 0) gen(abort_at, sel ? 3 : 255, t_eff);
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            start = (c == 0 || c == abort_at);
            pause = pause_s[c];
            @(posedge clk);
            #1;
            obs = sel ? {21'd0, busy2, done2, spk2, 6'd0, rif2.rom_addr}
                      : {21'd0, busy, done, spk, rif.rom_addr};
            check($sformatf("%s_c%0d", sel ? "small" : "main", c), obs, exp_v[c]);
        end
        @(negedge clk);
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    initial begin
        clear_mem();
        clear_pause();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_spk", 32'(spk), 0);
        check("rst_addr", 32'(rif.rom_addr), 0);

        // A3 then A4, long enough to see several tone half-periods.
        mem[0] = {4'd3, 6'h09};
        mem[1] = {4'd3, 6'h19};
        tempo = TW'(2000);
        run(0, -1);

        // Rest with tempo 0 (treated as 1).
        clear_mem();
        mem[0] = {4'd2, 6'h0C};
        tempo = '0;
        run(0, -1);

        // 7-cycle pause in the middle of a toggling note.
        clear_mem();
        mem[0] = {4'd2, 6'h39};
        tempo = TW'(400);
        for (int i = 300; i < 307; i++) pause_s[i] = 1'b1;
        run(0, -1);
        clear_pause();

        // Restart while rom_addr is 5 and the note is playing.
        clear_mem();
        for (int i = 0; i < 7; i++) mem[i] = {4'd1, 6'h3C};
        tempo = TW'(5);
        run(0, 39);

        for (int s = 0; s < 5; s++) begin
            int n, p0;
            n = $urandom_range(1, 5);
            clear_mem();
            for (int i = 0; i < n; i++)
                mem[i] = {4'($urandom_range(1, 3)), 2'($urandom_range(2, 3)),
                          4'($urandom_range(0, 15))};
            tempo = TW'($urandom_range(40, 250));
            clear_pause();
            if ($urandom_range(0, 1) == 1) begin
                p0 = $urandom_range(3, 400);
                for (int k = 0; k < int'($urandom_range(1, 10)); k++) pause_s[p0 + k] = 1'b1;
            end
            run(0, ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 600)) : -1);
        end
        clear_pause();

        // Small address space: stop after the last word, address held there.
        clear_mem();
        for (int i = 0; i < 4; i++) mem[i] = {4'd1, 6'($urandom_range(0, 63))};
        tempo = TW'(1);
        run(1, -1);

        // Asynchronous reset in the middle of a note that has spk high.
        clear_mem();
        mem[0] = {4'd3, 6'h39};
        tempo = TW'(400);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (300) @(negedge clk);
        check("pre_rst_spk", 32'(spk), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_spk", 32'(spk), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_addr", 32'(rif.rom_addr), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_spk", 32'(spk), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
